// File: rtl/proc_run_ctrl_pkg.sv
// proc_dbg_pkg: run-controller state/status encodings shared by the controller, core top and bench
package proc_dbg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} run_state_e;
  typedef enum logic [1:0] {NONE, HALT, TIMEOUT, OVERFLOW} run_status_e;
  localparam logic [31:0] HALT_EBREAK = 32'h00100073;
endpackage

// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if: program load stream into the controller and register dump stream out of it
interface proc_run_ctrl_if #(parameter int XLEN = 32);
  logic ld_valid, ld_ready, ld_last;
  logic [XLEN-1:0] ld_data;
  logic dump_valid, dump_ready, dump_last;
  logic [4:0] dump_idx;
  logic [XLEN-1:0] dump_data;
  modport master (output ld_valid, ld_data, ld_last, dump_ready,
                  input ld_ready, dump_valid, dump_idx, dump_data, dump_last);
  modport slave (input ld_valid, ld_data, ld_last, dump_ready,
                 output ld_ready, dump_valid, dump_idx, dump_data, dump_last);
endinterface

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: loads a program, runs the core to EBREAK or cycle budget, then dumps the reg file
module proc_run_ctrl
  import proc_dbg_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int NUM_REGS = 32,
  parameter int MAX_CYCLES = 1024,
  parameter logic [XLEN-1:0] HALT_INSN = XLEN'(HALT_EBREAK),
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  proc_run_ctrl_if.slave  io,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_rst,
  output logic            cpu_en,
  input  logic [XLEN-1:0] cpu_inst,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status,
  output logic [31:0]     cycle_count
);
  localparam logic [AW-1:0] ADDR_MAX = AW'(IMEM_DEPTH - 1);
  localparam logic [4:0] IDX_MAX = 5'(NUM_REGS - 1);
  localparam logic [31:0] CYC_MAX = 32'(MAX_CYCLES - 1);
  run_state_e state, state_d;
  run_status_e st;
  logic [AW-1:0] addr;
  logic [4:0] idx;
  logic go, xfer, hs, halt, tmo, ovf;
  always_comb begin
    go = (state == IDLE || state == DONE) && start;
    xfer = state == LOAD && io.ld_valid;
    hs = state == DUMP && io.dump_ready;
    halt = state == RUN && cpu_inst == HALT_INSN;
    tmo = state == RUN && cycle_count == CYC_MAX;
    ovf = xfer && !io.ld_last && addr == ADDR_MAX;
    state_d = state;
    case (state)
      IDLE, DONE: state_d = go ? LOAD : state;
      LOAD: state_d = (xfer && io.ld_last) ? RUN : ovf ? DUMP : LOAD;
      RUN: state_d = (halt || tmo) ? DUMP : RUN;
      DUMP: state_d = (hs && io.dump_last) ? DONE : DUMP;
      default: state_d = IDLE;
    endcase
    io.ld_ready = state == LOAD;
    imem_we = xfer;
    imem_addr = addr;
    imem_wdata = io.ld_data;
    cpu_rst = state == IDLE || state == LOAD || state == DONE;
    cpu_en = state == RUN;
    rf_raddr = idx;
    io.dump_valid = state == DUMP;
    io.dump_idx = idx;
    io.dump_data = rf_rdata;
    io.dump_last = state == DUMP && idx == IDX_MAX;
    busy = state == LOAD || state == RUN || state == DUMP;
    done = state == DONE;
    status = st;
  end
  // halt wins over timeout and is not itself counted as a run cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      idx <= '0;
      cycle_count <= '0;
      st <= NONE;
    end else begin
      state <= state_d;
      if (go) begin
        addr <= '0;
        cycle_count <= '0;
        st <= NONE;
      end
      if (xfer) addr <= addr + AW'(addr != ADDR_MAX);
      if (ovf) st <= OVERFLOW;
      if (state == RUN && halt) st <= HALT;
      else if (state == RUN) begin
        if (tmo) st <= TIMEOUT;
        cycle_count <= cycle_count + 32'(cycle_count != '1);
      end
      if (hs) idx <= io.dump_last ? 5'd0 : idx + 5'd1;
    end
  end
endmodule
